// File: rtl/key_debouncer_pkg.sv
// Shared types and default timing for the push-button debouncer.
// Channel state encoding plus production and simulation debounce lengths.
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_CNT_W           = 20;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/key_debounce_ch.sv
// One button: 2-flop synchroniser, debounce FSM and stability counter; pulses land
// DEBOUNCE_CYCLES+3 edges after the raw edge. No backpressure: outputs are strobes.
module key_debounce_ch
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_raw,
    output logic key_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic held,
    output logic press_set
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             release_set;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RELEASED: begin
                if (!s2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (s2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Edges are detected on the debounced level against its registered copy,
    // which puts the strobes in the same cycle as the key_db change.
    assign held        = (state == PRESSED) || (state == RELEASE_WAIT);
    assign press_set   = held & key_db;
    assign release_set = ~held & ~key_db;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            key_db        <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            key_db        <= ~held;
            press_pulse   <= press_set;
            release_pulse <= release_set;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low buttons, adds lowest-index press encoding and multi-press flag.
// All outputs share the per-channel output latency; no backpressure.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic              press_valid,
    output logic [1:0]        press_idx,
    output logic              multi_press
);

    logic [N_KEYS-1:0] held;
    logic [N_KEYS-1:0] press_set;
    logic [1:0]        idx_nxt;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .CLOCK_50      (CLOCK_50),
            .RESET_N       (RESET_N),
            .key_raw       (KEY[g]),
            .key_db        (key_db[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .held          (held[g]),
            .press_set     (press_set[g])
        );
    end

    // Scan high to low so the lowest pressed index wins.
    always_comb begin
        idx_nxt = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_set[i]) idx_nxt = 2'(i);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            press_valid <= 1'b0;
            press_idx   <= '0;
            multi_press <= 1'b0;
        end else begin
            press_valid <= |press_set;
            press_idx   <= idx_nxt;
            multi_press <= ($countones(held) > 1);
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random bouncing keys against a window model.
module tb_key_debouncer;
    import key_debouncer_pkg::*;

    localparam int N = 4;
    localparam int D = SIM_DEBOUNCE_CYCLES;

    logic         CLOCK_50 = 1'b0;
    logic         RESET_N;
    logic [N-1:0] KEY;
    logic [N-1:0] key_db;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         press_valid;
    logic [1:0]   press_idx;
    logic         multi_press;

    key_debouncer #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (DEFAULT_CNT_W)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .KEY           (KEY),
        .key_db        (key_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_valid   (press_valid),
        .press_idx     (press_idx),
        .multi_press   (multi_press)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a key's accepted level flips once the last D synchronised
    // samples all disagree with it; outputs show that level one edge later.
    logic         p1 [N];
    logic         p2 [N];
    logic [D-1:0] hist [N];
    logic [N-1:0] acc;
    logic [N-1:0] e_db, e_press, e_rel;
    logic         e_vld, e_multi;
    logic [1:0]   e_idx;
    bit           model_on = 0;
    logic         seen;
    bit           found;

    always @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int i = 0; i < N; i++) begin
                p1[i]   = 1'b1;
                p2[i]   = 1'b1;
                hist[i] = '1;
            end
            acc      = '1;
            e_db     = '1;
            e_press  = '0;
            e_rel    = '0;
            e_vld    = 1'b0;
            e_idx    = '0;
            e_multi  = 1'b0;
            model_on = 1;
        end else if (model_on) begin
            e_press = e_db & ~acc;
            e_rel   = ~e_db & acc;
            e_db    = acc;
            e_vld   = (e_press != 0);
            e_idx   = '0;
            found   = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && e_press[i]) begin
                    e_idx = 2'(i);
                    found = 1;
                end
            end
            e_multi = ($countones(~acc) >= 2);
            for (int i = 0; i < N; i++) begin
                seen    = p2[i];
                p2[i]   = p1[i];
                p1[i]   = KEY[i];
                hist[i] = {hist[i][D-2:0], seen};
                if (hist[i] == {D{~acc[i]}}) acc[i] = seen;
            end
        end
    end

    int           n_press = 0, n_rel = 0, m_press = 0;
    logic [N-1:0] last_pv, last_rv;
    logic [1:0]   last_idx;

    always @(negedge CLOCK_50) begin
        if (model_on) begin
            check("key_db", 32'(key_db), 32'(e_db));
            check("press_pulse", 32'(press_pulse), 32'(e_press));
            check("release_pulse", 32'(release_pulse), 32'(e_rel));
            check("press_valid", 32'(press_valid), 32'(e_vld));
            check("multi_press", 32'(multi_press), 32'(e_multi));
            if (e_vld) check("press_idx", 32'(press_idx), 32'(e_idx));
            if (e_vld) m_press++;
            if (press_valid) begin
                n_press++;
                last_pv  = press_pulse;
                last_idx = press_idx;
            end
            if (release_pulse != 0) begin
                n_rel++;
                last_rv = release_pulse;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
        #1;
    endtask

    int base;
    int hold_left [N];

    initial begin
        RESET_N = 1'b0;
        KEY     = '0;
        step(3);
        check("rst_key_db", 32'(key_db), 32'hF);
        check("rst_press", 32'(press_pulse), 32'h0);
        check("rst_multi", 32'(multi_press), 32'h0);
        RESET_N = 1'b1;
        KEY     = '1;
        step(10);
        check("idle_key_db", 32'(key_db), 32'hF);
        check("idle_npress", 32'(n_press), 32'h0);

        // Single stable press on KEY[2]
        base = n_press;
        KEY  = 4'b1011;
        step(12);
        check("k2_npress", 32'(n_press - base), 32'd1);
        check("k2_vec", 32'(last_pv), 32'b0100);
        check("k2_idx", 32'(last_idx), 32'd2);
        check("k2_key_db", 32'(key_db), 32'b1011);
        KEY = '1;
        step(12);

        // Glitch shorter than the debounce window
        base = n_press;
        KEY  = 4'b1101;
        step(2);
        KEY = '1;
        step(12);
        check("glitch_npress", 32'(n_press - base), 32'd0);
        check("glitch_key_db", 32'(key_db), 32'hF);

        // Press KEY[0], release with a bounce
        KEY = 4'b1110;
        step(12);
        base = n_rel;
        KEY  = '1;
        step(1);
        KEY = 4'b1110;
        step(2);
        KEY = '1;
        step(12);
        check("bounce_nrel", 32'(n_rel - base), 32'd1);
        check("bounce_vec", 32'(last_rv), 32'b0001);
        check("bounce_key_db", 32'(key_db), 32'hF);

        // Simultaneous KEY[3] and KEY[1]
        KEY = 4'b0101;
        step(12);
        check("dual_vec", 32'(last_pv), 32'b1010);
        check("dual_idx", 32'(last_idx), 32'd1);
        check("dual_multi", 32'(multi_press), 32'd1);
        KEY = '1;
        step(12);
        check("dual_multi_off", 32'(multi_press), 32'd0);

        // Reset in the middle of a press debounce
        base = n_press;
        KEY  = 4'b1110;
        step(3);
        RESET_N = 1'b0;
        step(1);
        RESET_N = 1'b1;
        step(D + 1);
        check("rstmid_early", 32'(n_press - base), 32'd0);
        step(8);
        check("rstmid_npress", 32'(n_press - base), 32'd1);
        KEY = '1;
        step(12);

        // Random bouncing keys with occasional resets
        for (int i = 0; i < N; i++) hold_left[i] = 1;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                hold_left[i]--;
                if (hold_left[i] <= 0) begin
                    KEY[i] = ~KEY[i];
                    hold_left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(D + 3, 20)
                                                               : $urandom_range(1, D + 1);
                end
            end
            RESET_N = ($urandom_range(0, 299) != 0);
            step(1);
        end
        RESET_N = 1'b1;
        step(4);
        check("total_presses", 32'(n_press), 32'(m_press));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream input stage for the mole-whacking game. Cleans the four raw active-low DE2 push-buttons before the game logic sees them.
- Synchronises each raw KEY into CLOCK_50 and debounces it with a per-key state machine.
- Outputs a debounced level vector in the same active-low format as the raw KEY bus, so it is a drop-in replacement.
- Also outputs single-cycle press/release events and an encoded "one key pressed" event, so the game scores each physical press exactly once.

Parameters:
- N_KEYS, 4, number of button channels.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range is 2..2^CNT_W-1.
- CNT_W, 20, width of each per-key stability counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  synchronous reset, active-low.
- KEY  in  N_KEYS  raw asynchronous buttons; 0 = pressed.
- key_db  out  N_KEYS  debounced level; 0 = pressed.
- press_pulse  out  N_KEYS  one-cycle strobe on each confirmed press.
- release_pulse  out  N_KEYS  one-cycle strobe on each confirmed release.
- press_valid  out  1  one-cycle strobe: at least one press_pulse bit is set this cycle.
- press_idx  out  2  index of the lowest set press_pulse bit; valid only with press_valid.
- multi_press  out  1  level: more than one key is in a pressed state (PRESSED or RELEASE_WAIT).

Behaviour:
- Reset (RESET_N=0 sampled at a CLOCK_50 edge):
  - Every channel goes to RELEASED with counter 0, and both synchroniser flops are set to 1.
  - key_db = all 1s.
  - press_pulse, release_pulse, press_valid, multi_press = 0; press_idx = 0.
  - Reset has priority over all other activity, including mid-debounce; any partial count is discarded.
- Synchroniser: 2 flops per key (s1, s2). The FSM sees s2, which lags KEY by 2 cycles.
- Per-channel FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - RELEASED: s2=0 -> PRESS_WAIT, cnt=1; otherwise stay, cnt=0.
  - PRESS_WAIT:
    - s2=1 -> RELEASED, cnt=0 (glitch rejected, no pulse).
    - else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, assert press_pulse next cycle.
    - else cnt+1.
  - PRESSED: s2=1 -> RELEASE_WAIT, cnt=1; otherwise stay.
  - RELEASE_WAIT:
    - s2=0 -> PRESSED, cnt=0 (bounce rejected).
    - else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED, cnt=0, assert release_pulse next cycle.
    - else cnt+1.
- Debounced level: key_db[i] = 0 exactly while channel i is in PRESSED or RELEASE_WAIT. It is registered and updates in the same cycle as press_pulse/release_pulse.
- Latency: a KEY fall first sampled at edge E, held stable, gives press_pulse high in the cycle after edge E+DEBOUNCE_CYCLES+2, for exactly 1 cycle. Release timing is symmetric.
- Holding a key gives no repeat pulses; a new press_pulse requires a confirmed release first.
- Encoded event:
  - press_valid and press_idx are registered in the same cycle as press_pulse.
  - Simultaneous confirmations are all reported in press_pulse, but press_idx reports only the lowest index (priority 0 > 1 > 2 > 3).
- multi_press is registered from the current channel states and has the same latency as key_db.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 by construction.
- Channels are fully independent; there is no shared counter.

Decomposition:
- Package key_debouncer_pkg holds:
  - the state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - DEFAULT_DEBOUNCE_CYCLES = 1_000_000 and DEFAULT_CNT_W = 20;
  - the simulation override value SIM_DEBOUNCE_CYCLES = 4.
- Sub-module key_debounce_ch: synchroniser, FSM and counter for one key; outputs level, press and release. It is instantiated N_KEYS times.
- The top level adds the priority encoder and the multi_press logic.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with KEY=0000 -> key_db=1111, all pulses 0; after release with KEY=1111 held, outputs stay idle.
- KEY[2] low from edge 0, stable -> press_pulse=0100, press_valid=1, press_idx=2 in the cycle after edge 6 only; key_db=1011 from then on.
- KEY[1] low for 2 cycles, then high (glitch shorter than 4) -> no press_pulse; key_db stays 1111.
- KEY[0] pressed and confirmed, then released with a 1-cycle high bounce, then held high -> no release_pulse during the bounce; release_pulse=0001 once, 4+2 cycles after the final rise; key_db returns to 1111.
- KEY[3] and KEY[1] fall on the same edge -> press_pulse=1010 in one cycle, press_idx=1, multi_press=1 from that cycle until either key is confirmed released.
- Reset asserted in the 2nd cycle of PRESS_WAIT on KEY[0] -> no press_pulse. After reset releases with KEY[0] still low, a full 4+2 cycle debounce is required before the pulse.
